// File: rtl/dpram_bist_ctrl.sv
// Dual-port RAM self-test initiator.
// Writes the pattern through port A and reads it back on B, then writes the inverse through B and reads it back on A.
module dpram_bist_ctrl #(
  parameter int          DEPTH = 256,
  parameter logic [15:0] SEED  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        we_a,
  output logic [7:0]  addr_a,
  output logic [15:0] data_a,
  output logic        we_b,
  output logic [7:0]  addr_b,
  output logic [15:0] data_b,
  input  logic [15:0] dataout_a,
  input  logic [15:0] dataout_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [7:0]  fail_addr,
  output logic [15:0] fail_data,
  output logic        fail_phase
);

  // state  | meaning
  // S_IDLE | waiting for start; RAM ports belong to system logic
  // S_W_A  | write P(k) through port A
  // S_R_B  | read through port B, last count value is the drain cycle
  // S_W_B  | write ~P(k) through port B
  // S_R_A  | read through port A, last count value is the drain cycle
  // S_DONE | single-cycle completion, done pulse
  typedef enum logic [2:0] {S_IDLE, S_W_A, S_R_B, S_W_B, S_R_A, S_DONE} state_t;

  localparam logic [8:0] LAST  = 9'(DEPTH - 1);
  localparam logic [8:0] DRAIN = 9'(DEPTH);

  function automatic logic [15:0] pat(input logic [7:0] k);
    return {k, ~k} ^ SEED;
  endfunction

  state_t      state, state_nx;
  logic [8:0]  cnt, cnt_nx, cnt_inc;
  logic        at_last, at_drain, abort_hit, clear, mismatch;
  logic        we_a_nx, we_b_nx;
  logic [7:0]  addr_a_nx, addr_b_nx;
  logic [15:0] data_a_nx, data_b_nx;
  logic        chk_vld, chk_vld_nx, chk_phase, chk_phase_nx;
  logic [7:0]  chk_addr, chk_addr_nx;
  logic [15:0] chk_exp, chk_exp_nx, rd_data;
  logic [7:0]  err_nx, fail_addr_nx;
  logic [15:0] fail_data_nx;
  logic        fail_phase_nx, pass_nx;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    cnt_inc      = cnt + 9'd1;
    at_last      = (cnt == LAST);
    at_drain     = (cnt == DRAIN);
    we_a_nx      = 1'b0;
    we_b_nx      = 1'b0;
    addr_a_nx    = addr_a;
    addr_b_nx    = addr_b;
    data_a_nx    = data_a;
    data_b_nx    = data_b;
    chk_vld_nx   = 1'b0;
    chk_phase_nx = chk_phase;
    chk_addr_nx  = chk_addr;
    chk_exp_nx   = chk_exp;
    clear        = 1'b0;
    abort_hit    = abort && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx  = S_W_A;
          cnt_nx    = 9'd0;
          we_a_nx   = 1'b1;
          addr_a_nx = 8'd0;
          data_a_nx = pat(8'd0);
          clear     = 1'b1;
        end
      end
      S_W_A: begin
        if (at_last) begin
          state_nx  = S_R_B;
          cnt_nx    = 9'd0;
          addr_b_nx = 8'd0;
        end else begin
          cnt_nx    = cnt_inc;
          we_a_nx   = 1'b1;
          addr_a_nx = cnt_inc[7:0];
          data_a_nx = pat(cnt_inc[7:0]);
        end
      end
      S_R_B: begin
        // expected value travels one stage behind the address, like the RAM read
        chk_vld_nx   = !at_drain;
        chk_phase_nx = 1'b0;
        chk_addr_nx  = cnt[7:0];
        chk_exp_nx   = pat(cnt[7:0]);
        if (at_drain) begin
          state_nx  = S_W_B;
          cnt_nx    = 9'd0;
          we_b_nx   = 1'b1;
          addr_b_nx = 8'd0;
          data_b_nx = ~pat(8'd0);
        end else begin
          cnt_nx = cnt_inc;
          if (!at_last) addr_b_nx = cnt_inc[7:0];
        end
      end
      S_W_B: begin
        if (at_last) begin
          state_nx  = S_R_A;
          cnt_nx    = 9'd0;
          addr_a_nx = 8'd0;
        end else begin
          cnt_nx    = cnt_inc;
          we_b_nx   = 1'b1;
          addr_b_nx = cnt_inc[7:0];
          data_b_nx = ~pat(cnt_inc[7:0]);
        end
      end
      S_R_A: begin
        chk_vld_nx   = !at_drain;
        chk_phase_nx = 1'b1;
        chk_addr_nx  = cnt[7:0];
        chk_exp_nx   = ~pat(cnt[7:0]);
        if (at_drain) begin
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt_inc;
          if (!at_last) addr_a_nx = cnt_inc[7:0];
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (abort_hit) begin
      state_nx   = S_IDLE;
      we_a_nx    = 1'b0;
      we_b_nx    = 1'b0;
      addr_a_nx  = addr_a;
      addr_b_nx  = addr_b;
      data_a_nx  = data_a;
      data_b_nx  = data_b;
      chk_vld_nx = 1'b0;
    end
  end

  // a check still in flight when abort lands is dropped so results stay frozen
  always_comb begin
    rd_data       = chk_phase ? dataout_a : dataout_b;
    mismatch      = chk_vld && (rd_data != chk_exp) && !abort_hit;
    err_nx        = err_count;
    fail_addr_nx  = fail_addr;
    fail_data_nx  = fail_data;
    fail_phase_nx = fail_phase;
    pass_nx       = pass;
    if (clear) begin
      err_nx        = 8'd0;
      fail_addr_nx  = 8'd0;
      fail_data_nx  = 16'd0;
      fail_phase_nx = 1'b0;
      pass_nx       = 1'b0;
    end else begin
      if (mismatch && err_count != 8'hFF) err_nx = err_count + 8'd1;
      if (mismatch && err_count == 8'd0) begin
        fail_addr_nx  = chk_addr;
        fail_data_nx  = rd_data;
        fail_phase_nx = chk_phase;
      end
      if (abort_hit)                pass_nx = 1'b0;
      else if (state_nx == S_DONE)  pass_nx = (err_nx == 8'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 9'd0;
      we_a       <= 1'b0;
      addr_a     <= 8'd0;
      data_a     <= 16'd0;
      we_b       <= 1'b0;
      addr_b     <= 8'd0;
      data_b     <= 16'd0;
      chk_vld    <= 1'b0;
      chk_phase  <= 1'b0;
      chk_addr   <= 8'd0;
      chk_exp    <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      fail_addr  <= 8'd0;
      fail_data  <= 16'd0;
      fail_phase <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      we_a       <= we_a_nx;
      addr_a     <= addr_a_nx;
      data_a     <= data_a_nx;
      we_b       <= we_b_nx;
      addr_b     <= addr_b_nx;
      data_b     <= data_b_nx;
      chk_vld    <= chk_vld_nx;
      chk_phase  <= chk_phase_nx;
      chk_addr   <= chk_addr_nx;
      chk_exp    <= chk_exp_nx;
      busy       <= (state_nx != S_IDLE);
      done       <= (state_nx == S_DONE);
      pass       <= pass_nx;
      err_count  <= err_nx;
      fail_addr  <= fail_addr_nx;
      fail_data  <= fail_data_nx;
      fail_phase <= fail_phase_nx;
    end
  end

endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// Directed bench: an 8-word instance on a fault-injectable RAM and a 256-word instance
// on a RAM whose port-B read of address 255 has bit0 stuck at 1.
module tb_dpram_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start8 = 1'b0, abort8 = 1'b0;
  logic        we_a8, we_b8, busy8, done8, pass8, fail_phase8;
  logic [7:0]  addr_a8, addr_b8, err_count8, fail_addr8;
  logic [15:0] data_a8, data_b8, dout_a8, dout_b8, fail_data8;

  logic        start256 = 1'b0, abort256 = 1'b0;
  logic        we_a256, we_b256, busy256, done256, pass256, fail_phase256;
  logic [7:0]  addr_a256, addr_b256, err_count256, fail_addr256;
  logic [15:0] data_a256, data_b256, dout_a256, dout_b256, fail_data256;

  dpram_bist_ctrl #(.DEPTH(8), .SEED(16'h0000)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8),
    .we_a(we_a8), .addr_a(addr_a8), .data_a(data_a8),
    .we_b(we_b8), .addr_b(addr_b8), .data_b(data_b8),
    .dataout_a(dout_a8), .dataout_b(dout_b8),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err_count8),
    .fail_addr(fail_addr8), .fail_data(fail_data8), .fail_phase(fail_phase8)
  );

  dpram_bist_ctrl #(.DEPTH(256), .SEED(16'h0000)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .abort(abort256),
    .we_a(we_a256), .addr_a(addr_a256), .data_a(data_a256),
    .we_b(we_b256), .addr_b(addr_b256), .data_b(data_b256),
    .dataout_a(dout_a256), .dataout_b(dout_b256),
    .busy(busy256), .done(done256), .pass(pass256), .err_count(err_count256),
    .fail_addr(fail_addr256), .fail_data(fail_data256), .fail_phase(fail_phase256)
  );

  // synchronous dual-port RAM models
  logic [15:0] mem8 [0:255];
  logic [15:0] mem256 [0:255];
  logic [15:0] q_a8, q_b8, q_a256, q_b256;
  logic [7:0]  ra8, rb8, ra256, rb256;
  logic        fault_a8 = 1'b0, fault_b8 = 1'b0;

  always @(posedge clk) begin
    if (we_a8) mem8[addr_a8] <= data_a8;
    if (we_b8) mem8[addr_b8] <= data_b8;
    q_a8 <= mem8[addr_a8];
    q_b8 <= mem8[addr_b8];
    ra8  <= addr_a8;
    rb8  <= addr_b8;
    if (we_a256) mem256[addr_a256] <= data_a256;
    if (we_b256) mem256[addr_b256] <= data_b256;
    q_a256 <= mem256[addr_a256];
    q_b256 <= mem256[addr_b256];
    ra256  <= addr_a256;
    rb256  <= addr_b256;
  end

  assign dout_a8   = (fault_a8 && ra8 == 8'd5) ? 16'h0000 : q_a8;
  assign dout_b8   = (fault_b8 && rb8 == 8'd3) ? (q_b8 | 16'h0001) : q_b8;
  assign dout_a256 = q_a256;
  assign dout_b256 = (rb256 == 8'hFF) ? (q_b256 | 16'h0001) : q_b256;

  logic [15:0] wa_exp [0:7];
  initial begin
    wa_exp[0] = 16'h00FF; wa_exp[1] = 16'h01FE; wa_exp[2] = 16'h02FD; wa_exp[3] = 16'h03FC;
    wa_exp[4] = 16'h04FB; wa_exp[5] = 16'h05FA; wa_exp[6] = 16'h06F9; wa_exp[7] = 16'h07F8;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives a one-cycle start into dut8, leaves time at cycle 1
  task automatic pulse_start8();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // waits for done8 from cycle 1, returns cycle number or the limit
  task automatic wait_done8(output int n);
    n = 1;
    while (!done8 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({we_a8, addr_a8, data_a8, we_b8, addr_b8, data_b8, busy8, done8, pass8,
         err_count8, fail_addr8, fail_data8, fail_phase8} !== '0) begin
      errors++;
      $display("FAIL reset_outputs8: got nonzero outputs busy=%0b we_a=%0b addr_a=%0h", busy8, we_a8, addr_a8);
    end
    checks++;
    if ({we_a256, addr_a256, busy256, done256, pass256, err_count256} !== '0) begin
      errors++;
      $display("FAIL reset_outputs256: got busy=%0b addr_a=%0h err=%0d", busy256, addr_a256, err_count256);
    end
  endtask

  task automatic test_good_run();
    pulse_start8();
    for (int c = 1; c <= 35; c++) begin
      if (c == 1) begin
        checks++;
        if (busy8 !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0b want 1", busy8); end
      end
      if (c <= 8) begin
        checks++;
        if ({we_a8, addr_a8, data_a8} !== {1'b1, 8'(c - 1), wa_exp[c-1]}) begin
          errors++;
          $display("FAIL wa_write%0d: got we=%0b addr=%0h data=%h want we=1 addr=%0h data=%h",
                   c - 1, we_a8, addr_a8, data_a8, c - 1, wa_exp[c-1]);
        end
      end
      if (c == 9) begin
        checks++;
        if ({we_a8, we_b8, addr_b8} !== {1'b0, 1'b0, 8'd0}) begin
          errors++;
          $display("FAIL rb_first: got we_a=%0b we_b=%0b addr_b=%0h want 0 0 0", we_a8, we_b8, addr_b8);
        end
      end
      if (c == 18 || c == 25) begin
        checks++;
        if ({we_b8, addr_b8, data_b8} !== ((c == 18) ? {1'b1, 8'd0, 16'hFF00} : {1'b1, 8'd7, 16'hF807})) begin
          errors++;
          $display("FAIL wb_write_cycle%0d: got we=%0b addr=%0h data=%h", c, we_b8, addr_b8, data_b8);
        end
      end
      if (c == 34) begin
        checks++;
        if (done8 !== 1'b0) begin errors++; $display("FAIL done_early: got %0b want 0 at cycle 34", done8); end
      end
      if (c == 35) begin
        checks++;
        if ({done8, busy8, pass8, err_count8} !== {1'b1, 1'b1, 1'b1, 8'd0}) begin
          errors++;
          $display("FAIL good_done: got done=%0b busy=%0b pass=%0b err=%0d want 1 1 1 0", done8, busy8, pass8, err_count8);
        end
      end
      if (c < 35) tick();
    end
    tick();
    checks++;
    if ({done8, busy8, pass8, we_a8, we_b8} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL good_after: got done=%0b busy=%0b pass=%0b want 0 0 1", done8, busy8, pass8);
    end
    checks++;
    if ({addr_a8, addr_b8} !== {8'd7, 8'd7}) begin
      errors++;
      $display("FAIL idle_addr_hold: got addr_a=%0h addr_b=%0h want 7 7", addr_a8, addr_b8);
    end
  endtask

  task automatic test_fault_b();
    int n;
    fault_b8 = 1'b1;
    pulse_start8();
    checks++;
    if (pass8 !== 1'b0) begin errors++; $display("FAIL start_clears_pass: got %0b want 0", pass8); end
    wait_done8(n);
    checks++;
    if (n != 35 || done8 !== 1'b1) begin errors++; $display("FAIL fb_done_cycle: got %0d want 35", n); end
    checks++;
    if ({err_count8, fail_addr8, fail_data8, fail_phase8, pass8} !== {8'd1, 8'd3, 16'h03FD, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fault_b: got err=%0d addr=%0h data=%h phase=%0b pass=%0b want 1 3 03fd 0 0",
               err_count8, fail_addr8, fail_data8, fail_phase8, pass8);
    end
    fault_b8 = 1'b0;
    tick();
  endtask

  task automatic test_fault_a();
    int n;
    fault_a8 = 1'b1;
    pulse_start8();
    checks++;
    if ({err_count8, fail_addr8, fail_data8} !== '0) begin
      errors++;
      $display("FAIL start_clears_fail: got err=%0d addr=%0h data=%h want 0", err_count8, fail_addr8, fail_data8);
    end
    wait_done8(n);
    checks++;
    if ({err_count8, fail_addr8, fail_data8, fail_phase8, pass8} !== {8'd1, 8'd5, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fault_a: got err=%0d addr=%0h data=%h phase=%0b pass=%0b want 1 5 0000 1 0",
               err_count8, fail_addr8, fail_data8, fail_phase8, pass8);
    end
    fault_a8 = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int  n;
    logic seen_done;
    pulse_start8();
    repeat (20) tick();
    // now in cycle 21, the 4th W_B cycle
    checks++;
    if ({we_b8, addr_b8} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL abort_pre: got we_b=%0b addr_b=%0h want 1 3", we_b8, addr_b8);
    end
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    checks++;
    if ({busy8, we_b8, we_a8, pass8} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got busy=%0b we_b=%0b we_a=%0b pass=%0b want 0", busy8, we_b8, we_a8, pass8);
    end
    seen_done = 1'b0;
    repeat (40) begin
      if (done8 || busy8) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity=1 want 0"); end
    // abort and start together in IDLE: abort wins
    start8 = 1'b1; abort8 = 1'b1;
    tick();
    start8 = 1'b0; abort8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got busy=%0b want 0", busy8); end
    // rerun with a spurious start while busy
    pulse_start8();
    repeat (9) tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 11;
    while (!done8 && n < 60) begin tick(); n++; end
    checks++;
    if (n != 35 || {done8, pass8, err_count8} !== {1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL rerun_after_abort: got cycle=%0d pass=%0b err=%0d want 35 1 0", n, pass8, err_count8);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_start8();
    repeat (11) tick();
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL rbm_busy: got %0b want 1", busy8); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({we_a8, addr_a8, data_a8, we_b8, addr_b8, data_b8, busy8, done8, pass8,
         err_count8, fail_addr8, fail_data8, fail_phase8} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%0b addr_a=%0h data_a=%h addr_b=%0h", busy8, addr_a8, data_a8, addr_b8);
    end
    #3 rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL after_reset_idle: got busy=%0b want 0", busy8); end
  endtask

  task automatic test_depth256();
    int n;
    start256 = 1'b1;
    tick();
    start256 = 1'b0;
    n = 1;
    while (!done256 && n < 1100) begin tick(); n++; end
    checks++;
    if (n != 1027 || done256 !== 1'b1) begin
      errors++;
      $display("FAIL d256_done_cycle: got %0d want 1027", n);
    end
    checks++;
    if ({err_count256, fail_addr256, fail_data256, fail_phase256, pass256, addr_a256} !==
        {8'd1, 8'hFF, 16'hFF01, 1'b0, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL d256_last_addr: got err=%0d addr=%0h data=%h phase=%0b pass=%0b addr_a=%0h want 1 ff ff01 0 0 ff",
               err_count256, fail_addr256, fail_data256, fail_phase256, pass256, addr_a256);
    end
  endtask

  initial begin
    #12;
    test_reset();
    rst = 1'b1;
    tick();
    test_good_run();
    test_fault_b();
    test_fault_a();
    test_abort();
    test_reset_mid();
    test_depth256();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
